// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
//   Instruction-cache refill controller. On a fetch miss it issues one burst
//   request for the enclosing cache line. It then writes each returned beat
//   into the cache data array, one word per cycle. It ends with a one-cycle
//   done or error pulse.
//
//   Optional feature macro: ICACHE_CRITICAL_WORD_FIRST_EN
//     defined   : the burst starts at the missed word and wraps within the line
//     undefined : the burst always starts at word 0 of the line
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   miss_valid/addr     miss from the fetch stage; miss_ready is high in IDLE only
//   mem_req_*           burst request (valid/ready), word-aligned first-beat address
//   mem_rsp_*           response beats; mem_rsp_err is qualified by mem_rsp_valid
//   refill_we/address/data  registered write port into the cache array
//   refill_done/error   one-cycle completion / abort pulses
//   busy                controller is not idle
module icache_refill_ctrl #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              refill_we,
  output logic [ADDR_W-1:0] refill_address,
  output logic [31:0]       refill_data,
  output logic              refill_done,
  output logic              refill_error,
  output logic              busy
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_BURST, S_DONE, S_ERR
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } refill_t;

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;      // line base without the offset bits
  logic [IDX_W-1:0]  idx_q, idx_d;      // word index inside the line, wraps naturally
  logic [IDX_W-1:0]  cnt_q, cnt_d;      // beats accepted so far
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  refill_t           wr_q, wr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  start_idx;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign start_idx = miss_addr[OFF_W-1:2];
`else
  assign start_idx = '0;
`endif

  // Byte-offset bits of the miss address are only partly consumed.
  logic unused_miss_bits;
  assign unused_miss_bits = ^miss_addr[OFF_W-1:0];

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    wr_d        = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss_valid) begin
          tag_d       = miss_addr[ADDR_W-1:OFF_W];
          idx_d       = start_idx;
          cnt_d       = '0;
          req_valid_d = 1'b1;
          req_addr_d  = {miss_addr[ADDR_W-1:OFF_W], start_idx, 2'b00};
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        // Address register is untouched here, so it stays stable while stalled.
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = S_BURST;
        end
      end
      S_BURST: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            wr_d.we   = 1'b1;
            wr_d.addr = {tag_q, idx_q, 2'b00};
            wr_d.data = mem_rsp_data;
            idx_d     = idx_q + IDX_W'(1);
            cnt_d     = cnt_q + IDX_W'(1);
            if (cnt_q == LAST_BEAT) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tag_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      wr_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      wr_q        <= wr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign miss_ready     = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign mem_req_valid  = req_valid_q;
  assign mem_req_addr   = req_addr_q;
  assign refill_we      = wr_q.we;
  assign refill_address = wr_q.addr;
  assign refill_data    = wr_q.data;
  assign refill_done    = done_q;
  assign refill_error   = err_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl. Stimulus tasks script each
// refill. For every cycle they state what the outputs must be, using line
// arithmetic. A negedge compare process checks the DUT against those
// expectations.
module tb_icache_refill_ctrl;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_valid = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        miss_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;
  logic        refill_we;
  logic [31:0] refill_address;
  logic [31:0] refill_data;
  logic        refill_done;
  logic        refill_error;
  logic        busy;

  icache_refill_ctrl #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .refill_we(refill_we), .refill_address(refill_address), .refill_data(refill_data),
    .refill_done(refill_done), .refill_error(refill_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Expected outputs for the current cycle.
  bit          chk_en = 1'b0;
  logic        e_miss_ready, e_busy, e_req_valid, e_we, e_done, e_err;
  logic [31:0] e_req_addr, e_waddr, e_wdata;

  // Observations used by the literal checks.
  logic [31:0] obs_a[$];
  logic [31:0] obs_d[$];
  logic [31:0] last_req = '0;
  int          n_done = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Line arithmetic: address of the b-th beat of a refill for miss address a.
  function automatic logic [31:0] start_word(input logic [31:0] a);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    return (a >> 2) % LW;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int b);
    logic [31:0] base;
    base = a & ~(32'(LW * 4) - 32'd1);
    return base + 32'd4 * ((start_word(a) + 32'(b)) % LW);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("miss_ready", miss_ready, e_miss_ready);
      chk("busy", busy, e_busy);
      chk("mem_req_valid", mem_req_valid, e_req_valid);
      if (e_req_valid) chk("mem_req_addr", mem_req_addr, e_req_addr);
      chk("refill_we", refill_we, e_we);
      if (e_we) begin
        chk("refill_address", refill_address, e_waddr);
        chk("refill_data", refill_data, e_wdata);
      end
      chk("refill_done", refill_done, e_done);
      chk("refill_error", refill_error, e_err);
      if (refill_we) begin
        obs_a.push_back(refill_address);
        obs_d.push_back(refill_data);
      end
      if (mem_req_valid) last_req = mem_req_addr;
      n_done += int'(refill_done);
      n_err  += int'(refill_error);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    e_miss_ready = 1'b1; e_busy = 1'b0; e_req_valid = 1'b0;
    e_we = 1'b0; e_done = 1'b0; e_err = 1'b0;
  endtask

  task automatic exp_busy();
    e_miss_ready = 1'b0; e_busy = 1'b1; e_req_valid = 1'b0;
    e_we = 1'b0; e_done = 1'b0; e_err = 1'b0;
  endtask

  task automatic clear_obs();
    obs_a.delete(); obs_d.delete(); n_done = 0; n_err = 0;
  endtask

  // One refill, starting in an idle cycle. err_beat < 0: no error.
  // abort_after >= 0: return right after that beat's write becomes visible.
  task automatic run_miss(input logic [31:0] a, input int req_wait, input int err_beat,
                          input bit gaps, input bit rsp_in_req, input bit fixed,
                          input bit hold_next, input logic [31:0] next_a,
                          input int abort_after);
    int  b;
    bit  fin, gap;
    logic [31:0] d;
    miss_valid = 1'b1; miss_addr = a;
    step();
    exp_busy(); e_req_valid = 1'b1; e_req_addr = beat_addr(a, 0);
    miss_valid = 1'b0;
    for (int w = 0; w < req_wait; w++) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = rsp_in_req ? 1'($urandom) : 1'b0;
      mem_rsp_data = $urandom; mem_rsp_err = 1'($urandom);
      step();
    end
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    step();
    exp_busy();
    mem_req_ready = 1'b0;
    b = 0; fin = 1'b0;
    while (!fin) begin
      gap = gaps && ($urandom_range(0, 2) == 0);
      d = fixed ? 32'hA0 + 32'(b) : $urandom;
      if (gap) begin
        mem_rsp_valid = 1'b0; mem_rsp_data = d; mem_rsp_err = 1'($urandom);
      end else begin
        mem_rsp_valid = 1'b1; mem_rsp_data = d; mem_rsp_err = (b == err_beat);
      end
      if (hold_next) begin
        miss_valid = 1'b1; miss_addr = next_a;
      end
      step();
      exp_busy();
      if (!gap) begin
        if (b == err_beat) begin
          e_err = 1'b1; fin = 1'b1;
        end else begin
          e_we = 1'b1; e_waddr = beat_addr(a, b); e_wdata = d;
          if (b == LW - 1) begin
            e_done = 1'b1; fin = 1'b1;
          end
          if (b == abort_after) return;
        end
        b++;
      end
    end
    // Stray beats in DONE/ERR must never produce a write.
    mem_rsp_valid = 1'($urandom); mem_rsp_data = $urandom; mem_rsp_err = 1'($urandom);
    step();
    exp_idle();
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      mem_rsp_valid = 1'($urandom); mem_rsp_data = $urandom; mem_rsp_err = 1'($urandom);
      step();
    end
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst miss_ready", miss_ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst mem_req_valid", mem_req_valid, 1'b0);
    chk("rst mem_req_addr", mem_req_addr, 32'h0);
    chk("rst refill_we", refill_we, 1'b0);
    chk("rst refill_address", refill_address, 32'h0);
    chk("rst refill_data", refill_data, 32'h0);
    chk("rst refill_done", refill_done, 1'b0);
    chk("rst refill_error", refill_error, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] lit_addr [LW];

  initial begin
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    lit_addr = '{32'h114, 32'h118, 32'h11C, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
`else
    lit_addr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h11C};
`endif
    #3;
    chk_reset_outputs();
    #9 rst_n = 1'b1;
    step();
    exp_idle();
    chk_en = 1'b1;
    step();

    // Directed line refill with known data.
    clear_obs();
    run_miss(32'h0000_0114, 0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, -1);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    chk("lit req_addr", last_req, 32'h114);
`else
    chk("lit req_addr", last_req, 32'h100);
`endif
    chk("lit write count", 32'(obs_a.size()), 32'd8);
    for (int i = 0; i < LW && i < obs_a.size(); i++) begin
      chk("lit write addr", obs_a[i], lit_addr[i]);
      chk("lit write data", obs_d[i], 32'hA0 + 32'(i));
    end
    chk("lit done count", 32'(n_done), 32'd1);

    // Stalled request with stray beats during REQ.
    clear_obs();
    run_miss(32'h0000_2468, 5, -1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, -1);
    chk("stall write count", 32'(obs_a.size()), 32'd8);

    // Error on beat 3.
    clear_obs();
    run_miss(32'h0000_0304, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, -1);
    chk("err write count", 32'(obs_a.size()), 32'd3);
    chk("err pulse count", 32'(n_err), 32'd1);
    chk("err done count", 32'(n_done), 32'd0);
    idle_cycles(2);

    // Second miss held during the burst.
    clear_obs();
    run_miss(32'h0000_1000, 1, -1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_5A5C, -1);
    run_miss(32'h0000_5A5C, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, -1);
    chk("held done count", 32'(n_done), 32'd2);
    chk("held req_addr", last_req, beat_addr(32'h0000_5A5C, 0));

    // Reset in the middle of a burst, just after beat 4's write appears.
    clear_obs();
    run_miss(32'h0000_0a20, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4);
    #2;
    chk_en = 1'b0;
    chk("pre-reset refill_we", refill_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    mem_rsp_valid = 1'b0;
    step(); step();
    #2 rst_n = 1'b1;
    step();
    exp_idle();
    chk_en = 1'b1;
    chk("reset done count", 32'(n_done), 32'd0);
    clear_obs();
    run_miss(32'h0000_0b3c, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, -1);
    chk("post-reset done count", 32'(n_done), 32'd1);

    // Randomized refills.
    for (int t = 0; t < 40; t++) begin
      int eb;
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
      run_miss($urandom, int'($urandom_range(0, 4)), eb, 1'($urandom), 1'($urandom),
               1'b0, 1'b0, 32'h0, -1);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
